// File: rtl/inject_one_flit_pkg.sv
// inject_one_flit_pkg
//   Shared types and defaults for the flit injection stage.
//   flit_int_t     : internal flit format carried on each pipeline channel
//   WIDTH_FLIT_INT : packed width of flit_int_t
//   INJ_DEPTH      : default injection-queue depth
//   INJ_STARVE_THRESH : default blocked-cycle count that raises starved
package inject_one_flit_pkg;

   localparam int NUM_CHNL          = 4;
   localparam int WIDTH_FLIT_DATA   = 16;
   localparam int WIDTH_FLIT_DST    = 5;
   localparam int WIDTH_FLIT_INT    = 3 + WIDTH_FLIT_DST + WIDTH_FLIT_DATA;

   localparam int INJ_DEPTH         = 4;
   localparam int INJ_STARVE_THRESH = 8;

   typedef struct packed {
      logic                       valid;
      logic                       head;
      logic                       tail;
      logic [WIDTH_FLIT_DST-1:0]  dst;
      logic [WIDTH_FLIT_DATA-1:0] data;
   } flit_int_t;

   // Isolate the lowest set bit; all-zero in gives all-zero out.
   function automatic logic [NUM_CHNL-1:0] lowest_one_hot(input logic [NUM_CHNL-1:0] v);
      return v & (~v + NUM_CHNL'(1));
   endfunction

endpackage

// File: rtl/inj_fifo.sv
// inj_fifo
//   Injection queue: DEPTH entries of flit_int_t, FIFO order.
//   clk, rst_n : clock, async active-low reset (clears occupancy/pointers)
//   push, din  : write din when push and not full
//   pop        : drop head when pop and not empty
//   head       : oldest entry (undefined content when empty)
//   full/empty : derived from the registered occupancy count only
module inj_fifo
   import inject_one_flit_pkg::*;
#(
   parameter int DEPTH = INJ_DEPTH
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  flit_int_t din,
   input  logic      pop,
   output flit_int_t head,
   output logic      full,
   output logic      empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   flit_int_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/inject_one_flit.sv
// inject_one_flit
//   Queues flits from the network interface and injects at most one per
//   cycle into the lowest-index free pipeline channel.
//   clk, rst_n       : clock, async active-low reset
//   din_0..din_3     : channel flits after ejection; .valid=0 means free
//   inj_flit/valid   : flit offered by the NI
//   inj_ready        : queue not full (registered occupancy only)
//   dout_0..dout_3   : registered channel flits, one may carry the injected flit
//   inj_chnl_vec     : registered one-hot of the channel injected, 0 if none
//   starved          : registered, queue blocked STARVE_THRESH+ cycles
module inject_one_flit
   import inject_one_flit_pkg::*;
#(
   parameter int DEPTH         = INJ_DEPTH,
   parameter int STARVE_THRESH = INJ_STARVE_THRESH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  flit_int_t  din_0,
   input  flit_int_t  din_1,
   input  flit_int_t  din_2,
   input  flit_int_t  din_3,
   input  flit_int_t  inj_flit,
   input  logic       inj_valid,
   output logic       inj_ready,
   output flit_int_t  dout_0,
   output flit_int_t  dout_1,
   output flit_int_t  dout_2,
   output flit_int_t  dout_3,
   output logic [3:0] inj_chnl_vec,
   output logic       starved
);

   localparam int SW = $clog2(STARVE_THRESH + 1);
   localparam logic [SW-1:0] STHR = SW'(STARVE_THRESH);

   flit_int_t [NUM_CHNL-1:0] din_a;
   flit_int_t [NUM_CHNL-1:0] dout_q;
   logic      [NUM_CHNL-1:0] free_vec, sel_vec, vec_q;
   flit_int_t                head, inj_out;
   logic                     fifo_full, fifo_empty, inj_go;
   logic      [SW-1:0]       stv_cnt, stv_nxt;
   logic                     stv_q;

   assign din_a = {din_3, din_2, din_1, din_0};

   for (genvar ch = 0; ch < NUM_CHNL; ch++) begin : g_free
      assign free_vec[ch] = ~din_a[ch].valid;
   end

   assign sel_vec   = lowest_one_hot(free_vec);
   assign inj_go    = ~fifo_empty & (|free_vec);
   assign inj_ready = ~fifo_full;

   // The queue never bypasses: head comes from storage written on an
   // earlier edge, so a fresh push waits at least one cycle.
   inj_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inj_valid),
      .din   (inj_flit),
      .pop   (inj_go),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      inj_out       = head;
      inj_out.valid = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
         vec_q  <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CHNL; ch++)
            dout_q[ch] <= (inj_go && sel_vec[ch]) ? inj_out : din_a[ch];
         vec_q <= inj_go ? sel_vec : '0;
      end
   end

   // Counts only while something waits and nothing leaves; saturates so it
   // never wraps back below the threshold.
   always_comb begin
      stv_nxt = stv_cnt;
      if (fifo_empty || inj_go) stv_nxt = '0;
      else if (stv_cnt < STHR)  stv_nxt = stv_cnt + SW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stv_cnt <= '0;
         stv_q   <= 1'b0;
      end else begin
         stv_cnt <= stv_nxt;
         stv_q   <= (stv_nxt >= STHR);
      end
   end

   assign dout_0       = dout_q[0];
   assign dout_1       = dout_q[1];
   assign dout_2       = dout_q[2];
   assign dout_3       = dout_q[3];
   assign inj_chnl_vec = vec_q;
   assign starved      = stv_q;

endmodule

// File: tb/tb_inject_one_flit.sv
// tb_inject_one_flit
//   Directed, table-driven bench: each row is one clock cycle of stimulus
//   with the hand-computed outputs expected right after that edge.
module tb_inject_one_flit;
   import inject_one_flit_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   flit_int_t  din_0, din_1, din_2, din_3, inj_flit;
   logic       inj_valid;
   logic       inj_ready;
   flit_int_t  dout_0, dout_1, dout_2, dout_3;
   logic [3:0] inj_chnl_vec;
   logic       starved;

   inject_one_flit #(.DEPTH(4), .STARVE_THRESH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .din_0(din_0), .din_1(din_1), .din_2(din_2), .din_3(din_3),
      .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_ready(inj_ready),
      .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2), .dout_3(dout_3),
      .inj_chnl_vec(inj_chnl_vec), .starved(starved)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  mask;      // din valid bits
      logic        iv;        // inj_valid
      logic [15:0] idata;     // inj_flit data
      logic        exp_rdy;
      logic [3:0]  exp_vec;
      logic        exp_stv;
      logic [15:0] exp_data;  // data expected on the injected channel
   } vec_t;

   localparam int NROWS = 33;
   vec_t tbl [NROWS];

   int n_chk  = 0;
   int n_pass = 0;

   function automatic vec_t mkv(logic [3:0] m, logic iv, logic [15:0] d,
                                logic r, logic [3:0] v, logic s, logic [15:0] e);
      vec_t t;
      t.mask = m; t.iv = iv; t.idata = d;
      t.exp_rdy = r; t.exp_vec = v; t.exp_stv = s; t.exp_data = e;
      return t;
   endfunction

   function automatic flit_int_t mk_din(int ch, logic [3:0] mask, int row);
      flit_int_t f;
      logic [31:0] c;
      c      = 32'(ch);
      f.valid = mask[ch];
      f.head  = c[0];
      f.tail  = 1'b0;
      f.dst   = 5'(ch);
      f.data  = 16'hD000 + 16'(row * 16 + ch);
      return f;
   endfunction

   // NI flits arrive with valid=0 in the payload so the forced valid shows.
   function automatic flit_int_t mk_inj(logic [15:0] d, logic v);
      flit_int_t f;
      f.valid = v; f.head = 1'b1; f.tail = 1'b1; f.dst = 5'h1F; f.data = d;
      return f;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(logic [3:0] mask, logic iv, logic [15:0] d, int row);
      din_0     = mk_din(0, mask, row);
      din_1     = mk_din(1, mask, row);
      din_2     = mk_din(2, mask, row);
      din_3     = mk_din(3, mask, row);
      inj_valid = iv;
      inj_flit  = mk_inj(d, 1'b0);
   endtask

   task automatic check_row(string tag, int row, logic [3:0] mask, logic r,
                            logic [3:0] v, logic s, logic [15:0] e);
      flit_int_t got [4];
      flit_int_t exp;
      got[0] = dout_0; got[1] = dout_1; got[2] = dout_2; got[3] = dout_3;
      chk($sformatf("%s[%0d].inj_ready", tag, row), 32'(inj_ready), 32'(r));
      chk($sformatf("%s[%0d].inj_chnl_vec", tag, row), 32'(inj_chnl_vec), 32'(v));
      chk($sformatf("%s[%0d].starved", tag, row), 32'(starved), 32'(s));
      for (int ch = 0; ch < 4; ch++) begin
         exp = v[ch] ? mk_inj(e, 1'b1) : mk_din(ch, mask, row);
         chk($sformatf("%s[%0d].dout_%0d", tag, row, ch), 32'(got[ch]), 32'(exp));
      end
   endtask

   task automatic check_reset_state(string tag);
      chk({tag, ".dout_0"}, 32'(dout_0), 32'h0);
      chk({tag, ".dout_1"}, 32'(dout_1), 32'h0);
      chk({tag, ".dout_2"}, 32'(dout_2), 32'h0);
      chk({tag, ".dout_3"}, 32'(dout_3), 32'h0);
      chk({tag, ".inj_chnl_vec"}, 32'(inj_chnl_vec), 32'h0);
      chk({tag, ".starved"}, 32'(starved), 32'h0);
      chk({tag, ".inj_ready"}, 32'(inj_ready), 32'h1);
   endtask

   initial begin
      // single push then inject on ch0; second flit lands on ch2
      tbl[0]  = mkv(4'b0000, 1, 16'h00A1, 1, 4'b0000, 0, 16'h0);
      tbl[1]  = mkv(4'b0000, 0, 16'h0,    1, 4'b0001, 0, 16'h00A1);
      tbl[2]  = mkv(4'b0011, 1, 16'h00B2, 1, 4'b0000, 0, 16'h0);
      tbl[3]  = mkv(4'b0011, 0, 16'h0,    1, 4'b0100, 0, 16'h00B2);
      // fill while blocked, 5th offer refused, drain in order on ch3
      tbl[4]  = mkv(4'b1111, 1, 16'h0C01, 1, 4'b0000, 0, 16'h0);
      tbl[5]  = mkv(4'b1111, 1, 16'h0C02, 1, 4'b0000, 0, 16'h0);
      tbl[6]  = mkv(4'b1111, 1, 16'h0C03, 1, 4'b0000, 0, 16'h0);
      tbl[7]  = mkv(4'b1111, 1, 16'h0C04, 0, 4'b0000, 0, 16'h0);
      tbl[8]  = mkv(4'b1111, 1, 16'h0C05, 0, 4'b0000, 0, 16'h0);
      tbl[9]  = mkv(4'b0111, 0, 16'h0,    1, 4'b1000, 0, 16'h0C01);
      tbl[10] = mkv(4'b0111, 0, 16'h0,    1, 4'b1000, 0, 16'h0C02);
      tbl[11] = mkv(4'b0111, 0, 16'h0,    1, 4'b1000, 0, 16'h0C03);
      tbl[12] = mkv(4'b0111, 0, 16'h0,    1, 4'b1000, 0, 16'h0C04);
      tbl[13] = mkv(4'b0111, 0, 16'h0,    1, 4'b0000, 0, 16'h0);
      // full with offer pending: pop first, then push+pop together
      tbl[14] = mkv(4'b1111, 1, 16'h0D01, 1, 4'b0000, 0, 16'h0);
      tbl[15] = mkv(4'b1111, 1, 16'h0D02, 1, 4'b0000, 0, 16'h0);
      tbl[16] = mkv(4'b1111, 1, 16'h0D03, 1, 4'b0000, 0, 16'h0);
      tbl[17] = mkv(4'b1111, 1, 16'h0D04, 0, 4'b0000, 0, 16'h0);
      tbl[18] = mkv(4'b0111, 1, 16'h0D05, 1, 4'b1000, 0, 16'h0D01);
      tbl[19] = mkv(4'b0111, 1, 16'h0D05, 1, 4'b1000, 0, 16'h0D02);
      // eight blocked cycles -> starved, then one injection clears it
      for (int k = 20; k < 27; k++)
         tbl[k] = mkv(4'b1111, 0, 16'h0, 1, 4'b0000, 0, 16'h0);
      tbl[27] = mkv(4'b1111, 0, 16'h0,    1, 4'b0000, 1, 16'h0);
      tbl[28] = mkv(4'b1110, 0, 16'h0,    1, 4'b0001, 0, 16'h0D03);
      tbl[29] = mkv(4'b1111, 0, 16'h0,    1, 4'b0000, 0, 16'h0);
      tbl[30] = mkv(4'b1110, 0, 16'h0,    1, 4'b0001, 0, 16'h0D04);
      // all free: still only one injection
      tbl[31] = mkv(4'b0000, 0, 16'h0,    1, 4'b0001, 0, 16'h0D05);
      tbl[32] = mkv(4'b0000, 0, 16'h0,    1, 4'b0000, 0, 16'h0);

      rst_n = 1'b0;
      drive(4'b0000, 1'b0, 16'h0, 0);
      #3;
      check_reset_state("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < NROWS; k++) begin
         drive(tbl[k].mask, tbl[k].iv, tbl[k].idata, k);
         @(posedge clk); #1;
         check_row("tbl", k, tbl[k].mask, tbl[k].exp_rdy, tbl[k].exp_vec,
                   tbl[k].exp_stv, tbl[k].exp_data);
      end

      // reset mid-operation with three flits queued
      for (int k = 0; k < 3; k++) begin
         drive(4'b1111, 1'b1, 16'h0E01 + 16'(k), 40 + k);
         @(posedge clk); #1;
      end
      drive(4'b1111, 1'b0, 16'h0, 43);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("async_rst");
      @(posedge clk); #1;
      check_reset_state("rst_held");
      @(negedge clk);
      rst_n = 1'b1;

      // no stale flit may appear even with every channel free
      for (int k = 0; k < 2; k++) begin
         drive(4'b0000, 1'b0, 16'h0, 50 + k);
         @(posedge clk); #1;
         check_row("post_rst", 50 + k, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0);
      end
      drive(4'b0000, 1'b1, 16'h0F01, 52);
      @(posedge clk); #1;
      check_row("post_rst", 52, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0);
      drive(4'b0000, 1'b0, 16'h0, 53);
      @(posedge clk); #1;
      check_row("post_rst", 53, 4'b0000, 1'b1, 4'b0001, 1'b0, 16'h0F01);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/inject_one_flit.md
INJECT_ONE_FLIT -- requirements
Module: inject_one_flit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of injection-queue entries (power of two, at least 2).
REQ-002 SHALL have parameter STARVE_THRESH, default 8, meaning the number of consecutive blocked cycles before starvation is flagged.
REQ-003 SHALL have ports, one per line:
  clk  input  1  single clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  din_0..din_3  input  flit_int_t each  pipeline flits after ejection; .valid=0 marks a free channel
  inj_flit  input  flit_int_t  flit offered by the network interface
  inj_valid  input  1  inj_flit is valid
  inj_ready  output  1  queue can accept inj_flit this cycle
  dout_0..dout_3  output  flit_int_t each  registered channel flits, one injected flit at most
  inj_chnl_vec  output  4  registered one-hot of the channel injected this cycle, 0 if none
  starved  output  1  registered, injection blocked STARVE_THRESH or more cycles

Function
REQ-004 SHALL accept a push when inj_valid and inj_ready are both high at a rising clk edge.
REQ-005 SHALL drive inj_ready = not full, derived only from registered occupancy, with no combinational path from inj_valid or din_*.
REQ-006 SHALL store queued flits in FIFO order; occupancy SHALL be a count in the range 0..DEPTH, with wrap-around read/write pointers of width log2(DEPTH).
REQ-007 SHALL compute the free vector as bit i = ~din_i.valid.
REQ-008 SHALL inject when the queue is non-empty and the free vector is non-zero, selecting the lowest-index free channel.
REQ-009 SHALL register dout_i = head flit with .valid forced to 1 for the selected channel, and dout_i = din_i for every other channel; latency din to dout is exactly 1 cycle.
REQ-010 SHALL pop the head on injection and set inj_chnl_vec to the selected one-hot in the same registered update.
REQ-011 SHALL inject no flit when the queue is empty or all four din_* are valid; in that case dout_i = din_i and inj_chnl_vec = 0.
REQ-012 SHALL support a simultaneous push and pop; occupancy is then unchanged.
REQ-013 SHALL NOT bypass the queue: a flit pushed into an empty queue is injectable one cycle later at the earliest.
REQ-014 SHALL inject at most one flit per cycle, even when several channels are free.
REQ-015 SHALL increment a saturating starve counter each cycle the queue is non-empty and no injection occurs, clear it on injection or when the queue is empty, and set starved = (counter >= STARVE_THRESH).

Reset
REQ-016 SHALL, on rst_n low and independent of clk, clear occupancy, pointers and the starve counter, drive dout_0..3 to all-zero, and drive inj_chnl_vec = 0, starved = 0, inj_ready = 1.
REQ-017 SHALL discard queued flits on reset mid-operation; the first push after rst_n deasserts is accepted normally.

Structure
REQ-018 SHALL take flit_int_t and WIDTH_FLIT_INT from flit.svh, and SHALL add INJ_DEPTH and INJ_STARVE_THRESH defaults to global.svh.
REQ-019 SHALL instantiate one sub-module, inj_fifo (DEPTH x flit_int_t, push/pop/full/empty/head); channel selection and output registers SHALL stay in the top level.

Verification
REQ-020 Empty queue, push flit A with din_0..3 all invalid -> next cycle no injection; the following cycle dout_0 = A with valid=1, inj_chnl_vec = 4'b0001.
REQ-021 Queue holds A, din_0 and din_1 valid, din_2 and din_3 free -> dout_2 = A, dout_3 = din_3, dout_0 = din_0, dout_1 = din_1, inj_chnl_vec = 4'b0100.
REQ-022 Push 4 flits with all din valid -> inj_ready = 0 after the 4th push; a 5th offer is not accepted; after freeing din_3, one pop per cycle in order A, B, C, D on channel 3.
REQ-023 Queue full with free channel and inj_valid high -> no push while full; the cycle after the pop, inj_ready = 1 and the push and next pop coexist with occupancy unchanged.
REQ-024 Queue non-empty, all din valid for 8 cycles -> starved = 1 in the cycle after the 8th blocked cycle; a free channel then gives one injection, and starved = 0 on the next cycle.
REQ-025 rst_n pulsed low with 3 flits queued -> all outputs are zero and inj_ready = 1 immediately; no stale flit is injected after release.
